// File: rtl/jtpopeye_sdram_rd.sv
// jtpopeye_sdram_rd: SDRAM-side responder for the game ROM request port.
// Runs the SDRAM power-up init, serves 32-bit ROM reads as 2-word bursts with
// auto-precharge, and schedules auto-refresh. Read-only; the DQ bus is never driven.
//
// Ports
//   clk_i, rst_i          system clock, asynchronous active-high reset
//   loop_rst_i            high: no new requests accepted; an in-flight burst completes
//   refresh_en_i          game permits refresh now (blanking)
//   sdram_req_i           level request, sampled only in idle
//   sdram_addr_i[21:0]    16-bit word address, bit 0 ignored
//   sdram_ack_o           1-cycle pulse: request accepted, address latched
//   data_rdy_o            1-cycle pulse: data_read_o valid
//   data_read_o[31:0]     {odd word, even word}, held until the next data_rdy_o
//   sdram_a_o, sdram_ba_o, sdram_n{cs,ras,cas,we}_o, sdram_dqm{l,h}_o, sdram_cke_o  SDRAM pins
//   sdram_dq_i[15:0]      DQ input
//
// Optional feature: define JTPOPEYE_FORCE_REFRESH_EN to add a forced-refresh timer that
// issues REF every REF_PERIOD cycles even when refresh_en_i stays low.
module jtpopeye_sdram_rd #(
  parameter int unsigned INIT_CYCLES = 4000,
  parameter int unsigned TRCD        = 1,
  parameter int unsigned CL          = 2,
  parameter int unsigned TRC         = 3,
  parameter int unsigned REF_PERIOD  = 312
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        loop_rst_i,
  input  logic        refresh_en_i,
  input  logic        sdram_req_i,
  input  logic [21:0] sdram_addr_i,
  output logic        sdram_ack_o,
  output logic        data_rdy_o,
  output logic [31:0] data_read_o,
  output logic [12:0] sdram_a_o,
  output logic [1:0]  sdram_ba_o,
  output logic        sdram_ncs_o,
  output logic        sdram_nras_o,
  output logic        sdram_ncas_o,
  output logic        sdram_nwe_o,
  output logic        sdram_dqml_o,
  output logic        sdram_dqmh_o,
  output logic        sdram_cke_o,
  input  logic [15:0] sdram_dq_i
);

  // {nCS, nRAS, nCAS, nWE}
  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdRead = 4'b0101;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdRef  = 4'b0001;
  localparam logic [3:0] CmdMrs  = 4'b0000;

  localparam logic [12:0] InitLoad   = 13'(INIT_CYCLES);
  localparam logic [3:0]  TrcdLoad   = 4'(TRCD - 1);
  localparam logic [3:0]  ClLoad     = 4'(CL);
  localparam logic [3:0]  TrcLoad    = 4'(TRC);
  // Idle is one extra cycle after the refresh wait, so TRC cycles separate REF and next cmd.
  localparam logic [3:0]  TrcRefLoad = 4'(TRC - 1);
  // Burst length 2, sequential, CAS latency CL.
  localparam logic [12:0] ModeReg    = 13'h020 | 13'(CL << 4) | 13'h001;

  typedef enum logic [3:0] {
    StInitWait, StInitPre, StInitRef1, StInitRef2, StInitMrs,
    StIdle, StAct, StRead, StData, StRef
  } state_e;

  state_e      state_q;
  logic [3:0]  cmd_q;
  logic [12:0] a_q;
  logic [1:0]  ba_q;
  logic [1:0]  dqm_q;
  logic        ack_q;
  logic        rdy_q;
  logic [31:0] data_q;
  logic [15:0] even_q;
  logic [12:0] col_q;
  logic [12:0] init_cnt_q;
  logic [3:0]  wait_q;
  logic        force_ref;
  logic        go_read;

  logic unused_addr0;
  assign unused_addr0 = sdram_addr_i[0];

`ifdef JTPOPEYE_FORCE_REFRESH_EN
  localparam logic [8:0] RefReload = 9'(REF_PERIOD - 1);
  logic [8:0] ref_cnt_q;

  // Reloads while a REF is on the bus; holds at zero until one is issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ref_cnt_q <= RefReload;
    end else if (cmd_q == CmdRef) begin
      ref_cnt_q <= RefReload;
    end else if (ref_cnt_q != 9'd0) begin
      ref_cnt_q <= ref_cnt_q - 9'd1;
    end
  end

  assign force_ref = (ref_cnt_q == 9'd0);
`else
  localparam int unsigned unused_ref_period = REF_PERIOD;
  assign force_ref = 1'b0;
`endif

  assign go_read = sdram_req_i & ~loop_rst_i;

  // State names the command currently on the bus (or the wait following it).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StInitWait;
      cmd_q      <= CmdNop;
      a_q        <= 13'd0;
      ba_q       <= 2'd0;
      dqm_q      <= 2'b11;
      ack_q      <= 1'b0;
      rdy_q      <= 1'b0;
      data_q     <= 32'd0;
      even_q     <= 16'd0;
      col_q      <= 13'd0;
      init_cnt_q <= InitLoad;
      wait_q     <= 4'd0;
    end else begin
      cmd_q <= CmdNop;
      ack_q <= 1'b0;
      rdy_q <= 1'b0;
      unique case (state_q)
        StInitWait: begin
          if (init_cnt_q == 13'd0) begin
            cmd_q   <= CmdPre;
            a_q     <= 13'h0400;
            state_q <= StInitPre;
          end else begin
            init_cnt_q <= init_cnt_q - 13'd1;
          end
        end
        StInitPre: begin
          cmd_q   <= CmdRef;
          wait_q  <= TrcLoad;
          state_q <= StInitRef1;
        end
        StInitRef1: begin
          if (wait_q == 4'd0) begin
            cmd_q   <= CmdRef;
            wait_q  <= TrcLoad;
            state_q <= StInitRef2;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StInitRef2: begin
          if (wait_q == 4'd0) begin
            cmd_q   <= CmdMrs;
            a_q     <= ModeReg;
            state_q <= StInitMrs;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StInitMrs: begin
          dqm_q   <= 2'b00;
          state_q <= StIdle;
        end
        StIdle: begin
          // A pending read beats refresh_en; only the forced timer beats a read.
          if (force_ref || (refresh_en_i && !go_read)) begin
            cmd_q   <= CmdRef;
            wait_q  <= TrcRefLoad;
            state_q <= StRef;
          end else if (go_read) begin
            cmd_q   <= CmdAct;
            ba_q    <= sdram_addr_i[21:20];
            a_q     <= {1'b0, sdram_addr_i[19:8]};
            col_q   <= {2'b00, 1'b1, 2'b00, sdram_addr_i[7:1], 1'b0};
            ack_q   <= 1'b1;
            wait_q  <= TrcdLoad;
            state_q <= StAct;
          end
        end
        StAct: begin
          if (wait_q == 4'd0) begin
            cmd_q   <= CmdRead;
            a_q     <= col_q;
            wait_q  <= ClLoad;
            state_q <= StRead;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StRead: begin
          if (wait_q == 4'd0) begin
            even_q  <= sdram_dq_i;
            state_q <= StData;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        StData: begin
          data_q  <= {sdram_dq_i, even_q};
          rdy_q   <= 1'b1;
          state_q <= StIdle;
        end
        StRef: begin
          if (wait_q == 4'd0) begin
            state_q <= StIdle;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        default: state_q <= StInitWait;
      endcase
    end
  end

  assign {sdram_ncs_o, sdram_nras_o, sdram_ncas_o, sdram_nwe_o} = cmd_q;
  assign sdram_a_o    = a_q;
  assign sdram_ba_o   = ba_q;
  assign sdram_dqmh_o = dqm_q[1];
  assign sdram_dqml_o = dqm_q[0];
  assign sdram_cke_o  = 1'b1;
  assign sdram_ack_o  = ack_q;
  assign data_rdy_o   = rdy_q;
  assign data_read_o  = data_q;

endmodule

// File: tb/tb_jtpopeye_sdram_rd.sv
// Bench for jtpopeye_sdram_rd: directed requests, expected bus events queued by the
// stimulus and checked in order (with cycle spacing) by a monitor.
module tb_jtpopeye_sdram_rd;

  localparam int InitCycles = 4000;
  localparam int Cl = 2;

  localparam logic [3:0] CmdNop  = 4'b0111;
  localparam logic [3:0] CmdAct  = 4'b0011;
  localparam logic [3:0] CmdRead = 4'b0101;
  localparam logic [3:0] CmdPre  = 4'b0010;
  localparam logic [3:0] CmdRef  = 4'b0001;
  localparam logic [3:0] CmdMrs  = 4'b0000;

  // Words returned by the SDRAM model, one pair per READ in issue order.
  localparam logic [15:0] EVEN_W [8] = '{16'hAAAA, 16'h1111, 16'h0000, 16'hDEAD,
                                         16'h1234, 16'h0F0F, 16'hCAFE, 16'h7777};
  localparam logic [15:0] ODD_W  [8] = '{16'h5555, 16'h2222, 16'hFFFF, 16'hBEEF,
                                         16'h5678, 16'hF0F0, 16'hF00D, 16'h8888};

  logic        clk = 1'b0;
  logic        rst, loop_rst, refresh_en, req;
  logic [21:0] addr;
  logic        ack, rdy;
  logic [31:0] data_read;
  logic [12:0] sd_a;
  logic [1:0]  sd_ba;
  logic        ncs, nras, ncas, nwe, dqml, dqmh, cke;
  logic [15:0] dq = 16'h0;
  logic [3:0]  cmd;
  logic [1:0]  dqm;

  assign cmd = {ncs, nras, ncas, nwe};
  assign dqm = {dqmh, dqml};

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jtpopeye_sdram_rd dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .loop_rst_i   (loop_rst),
    .refresh_en_i (refresh_en),
    .sdram_req_i  (req),
    .sdram_addr_i (addr),
    .sdram_ack_o  (ack),
    .data_rdy_o   (rdy),
    .data_read_o  (data_read),
    .sdram_a_o    (sd_a),
    .sdram_ba_o   (sd_ba),
    .sdram_ncs_o  (ncs),
    .sdram_nras_o (nras),
    .sdram_ncas_o (ncas),
    .sdram_nwe_o  (nwe),
    .sdram_dqml_o (dqml),
    .sdram_dqmh_o (dqmh),
    .sdram_cke_o  (cke),
    .sdram_dq_i   (dq)
  );

  // SDRAM model: even word CL cycles after READ is on the bus, odd word the cycle after.
  int         rd_cyc = -100;
  logic [2:0] rd_idx = 3'd0;
  logic [2:0] cur_idx = 3'd0;
  always @(negedge clk) begin
    if (cyc == rd_cyc + Cl) dq <= EVEN_W[cur_idx];
    else if (cyc == rd_cyc + Cl + 1) dq <= ODD_W[cur_idx];
    else dq <= 16'h0;
    if (cmd == CmdRead) begin
      rd_cyc  <= cyc;
      cur_idx <= rd_idx;
      rd_idx  <= rd_idx + 3'd1;
    end
  end

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        chk_a;
    logic        ack;
    logic        rdy;
    logic [31:0] data;
    logic [1:0]  dqm;
    int          gap;   // cycles since previous event (or reset release); -1 = any
  } ev_t;

  ev_t exp_q[$];
  int  ncmp = 0;
  int  nfail = 0;
  int  last_ev = 0;
  int  rel_cyc = 0;

  function automatic ev_t mk(string n, logic [3:0] c, logic [1:0] b, logic [12:0] a,
                             logic ca, logic ak, logic rd, logic [31:0] d,
                             logic [1:0] dm, int g);
    ev_t e;
    e.name = n; e.cmd = c; e.ba = b; e.a = a; e.chk_a = ca; e.ack = ak;
    e.rdy = rd; e.data = d; e.dqm = dm; e.gap = g;
    return e;
  endfunction

  task automatic push_read(string n, logic [1:0] b, logic [12:0] row, logic [12:0] col,
                           logic [31:0] d, int act_gap);
    exp_q.push_back(mk({n, "_act"}, CmdAct, b, row, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, act_gap));
    exp_q.push_back(mk({n, "_read"}, CmdRead, b, col, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1));
    exp_q.push_back(mk({n, "_rdy"}, CmdNop, b, 13'h0, 1'b0, 1'b0, 1'b1, d, 2'b00, 4));
  endtask

  task automatic push_init();
    exp_q.push_back(mk("init_pre", CmdPre, 2'd0, 13'h0400, 1'b1, 1'b0, 1'b0, 32'h0, 2'b11,
                       InitCycles + 1));
    exp_q.push_back(mk("init_ref1", CmdRef, 2'd0, 13'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b11, 1));
    exp_q.push_back(mk("init_ref2", CmdRef, 2'd0, 13'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b11, 4));
    exp_q.push_back(mk("init_mrs", CmdMrs, 2'd0, 13'h021, 1'b1, 1'b0, 1'b0, 32'h0, 2'b11, 4));
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic monitor();
    ev_t e;
    int  base, gap;
    bit  ok;
    forever begin
      @(negedge clk);
      if (cmd != CmdNop || ack || rdy) begin
        base = (rel_cyc > last_ev) ? rel_cyc : last_ev;
        gap = cyc - base;
        last_ev = cyc;
        ncmp++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected: got cmd=%b a=%h ack=%b rdy=%b at cycle %0d, want no event",
                   cmd, sd_a, ack, rdy, cyc);
        end else begin
          e = exp_q.pop_front();
          ok = (cmd == e.cmd) && (ack == e.ack) && (rdy == e.rdy) && (dqm == e.dqm) &&
               (!e.chk_a || (sd_a == e.a && sd_ba == e.ba)) &&
               (!e.rdy || data_read == e.data) && (e.gap < 0 || gap == e.gap);
          if (!ok) begin
            nfail++;
            $display({"FAIL %s: got cmd=%b ba=%0d a=%h ack=%b rdy=%b data=%h dqm=%b gap=%0d,",
                      " want cmd=%b ba=%0d a=%h ack=%b rdy=%b data=%h dqm=%b gap=%0d"},
                     e.name, cmd, sd_ba, sd_a, ack, rdy, data_read, dqm, gap,
                     e.cmd, e.ba, e.a, e.ack, e.rdy, e.data, e.dqm, e.gap);
          end
        end
      end
    end
  endtask

  task automatic drain(string name, int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ncmp++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL %s_timeout: got %0d events outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_ack(string name, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < budget);
    ncmp++;
    if (!ack) begin
      nfail++;
      $display("FAIL %s: got no ack in %0d cycles, want ack", name, budget);
    end
  endtask

  task automatic wait_cmd(string name, logic [3:0] c, int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd != c && n < budget);
    ncmp++;
    if (cmd != c) begin
      nfail++;
      $display("FAIL %s: got cmd=%b after %0d cycles, want %b", name, cmd, budget, c);
    end
  endtask

  task automatic do_init();
    repeat (3) @(negedge clk);
    push_init();
    rst = 1'b0;
    rel_cyc = cyc;
    drain("init", InitCycles + 100);
    repeat (2) @(negedge clk);
    check("idle_dqm", {30'd0, dqm}, 32'h0);
    check("idle_cmd", {28'd0, cmd}, {28'd0, CmdNop});
  endtask

  task automatic run_tests();
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd", {28'd0, cmd}, {28'd0, CmdNop});
    check("rst_a", {19'd0, sd_a}, 32'h0);
    check("rst_ba", {30'd0, sd_ba}, 32'h0);
    check("rst_dqm", {30'd0, dqm}, 32'h3);
    check("rst_cke", {31'd0, cke}, 32'h1);
    check("rst_ack_rdy", {30'd0, ack, rdy}, 32'h0);
    check("rst_data", data_read, 32'h0);
    do_init();

    // Single read
    push_read("rd0", 2'd1, 13'h0234, 13'h0456, 32'h5555_AAAA, -1);
    addr = 22'h12_3457;
    req = 1'b1;
    wait_ack("rd0_ack", 10);
    req = 1'b0;
    drain("rd0", 20);
    repeat (3) @(negedge clk);
    check("rd0_hold", data_read, 32'h5555_AAAA);

    // Back-to-back reads with req held, address changed after each ack
    push_read("bb1", 2'd3, 13'h0FFF, 13'h04FE, 32'h2222_1111, -1);
    push_read("bb2", 2'd0, 13'h0000, 13'h0400, 32'hFFFF_0000, 1);
    push_read("bb3", 2'd2, 13'h0ABC, 13'h04DE, 32'hBEEF_DEAD, 1);
    addr = 22'h3F_FFFF;
    req = 1'b1;
    wait_ack("bb1_ack", 10);
    addr = 22'h00_0001;
    wait_ack("bb2_ack", 20);
    addr = 22'h2A_BCDE;
    wait_ack("bb3_ack", 20);
    req = 1'b0;
    drain("bb", 30);
    repeat (4) @(negedge clk);

    // Lone refresh, then a request held off for TRC cycles
    exp_q.push_back(mk("ref_a", CmdRef, 2'd0, 13'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, -1));
    push_read("after_ref", 2'd0, 13'h0A5A, 13'h045A, 32'h5678_1234, 4);
    refresh_en = 1'b1;
    wait_cmd("ref_a_seen", CmdRef, 10);
    refresh_en = 1'b0;
    addr = 22'h0A_5A5A;
    req = 1'b1;
    wait_ack("after_ref_ack", 20);
    req = 1'b0;
    drain("after_ref", 30);
    repeat (4) @(negedge clk);

    // Simultaneous request and refresh_en: read first, REF right after data_rdy
    push_read("sim", 2'd1, 13'h0C0F, 13'h040E, 32'hF0F0_0F0F, -1);
    exp_q.push_back(mk("sim_ref", CmdRef, 2'd0, 13'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 1));
    addr = 22'h1C_0F0E;
    req = 1'b1;
    refresh_en = 1'b1;
    wait_ack("sim_ack", 10);
    req = 1'b0;
    wait_cmd("sim_ref_seen", CmdRef, 20);
    refresh_en = 1'b0;
    drain("sim", 20);
    repeat (6) @(negedge clk);

    // loop_rst one cycle after ack: burst completes, later requests ignored, REF allowed
    push_read("lr", 2'd3, 13'h0080, 13'h0480, 32'hF00D_CAFE, -1);
    addr = 22'h30_8081;
    req = 1'b1;
    wait_ack("lr_ack", 10);
    @(negedge clk);
    loop_rst = 1'b1;
    drain("lr", 20);
    repeat (10) @(negedge clk);
    exp_q.push_back(mk("lr_ref", CmdRef, 2'd0, 13'h0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00, -1));
    refresh_en = 1'b1;
    wait_cmd("lr_ref_seen", CmdRef, 10);
    refresh_en = 1'b0;
    drain("lr_ref", 10);
    repeat (8) @(negedge clk);
    loop_rst = 1'b0;
    req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset mid-burst: outputs drop at once, no data_rdy, init restarts
    exp_q.push_back(mk("rb_act", CmdAct, 2'd0, 13'h0102, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00, -1));
    exp_q.push_back(mk("rb_read", CmdRead, 2'd0, 13'h0402, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1));
    addr = 22'h01_0203;
    req = 1'b1;
    wait_ack("rb_ack", 10);
    req = 1'b0;
    wait_cmd("rb_read_seen", CmdRead, 5);
    #1 rst = 1'b1;
    #1;
    check("rb_cmd", {28'd0, cmd}, {28'd0, CmdNop});
    check("rb_dqm", {30'd0, dqm}, 32'h3);
    check("rb_a", {19'd0, sd_a}, 32'h0);
    check("rb_ba", {30'd0, sd_ba}, 32'h0);
    drain("rb", 2);
    do_init();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    loop_rst = 1'b0;
    refresh_en = 1'b0;
    req = 1'b0;
    addr = 22'h0;
    fork
      monitor();
      run_tests();
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
